// File: rtl/to8bit_ser_if.sv
// ============================================================================
//  Module      : to8bit_ser_if
//  Description : Word-intake and byte-output handshake bundle for to8bit_ser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface to8bit_ser_if;
    logic [1:0]  dataS;
    logic [31:0] dataIn;
    logic        inValid;
    logic        inReady;
    logic [7:0]  dataOut;
    logic        outValid;
    logic        outReady;
    logic [1:0]  contador;
    logic [1:0]  dataSInternal;

    // Serializer side
    modport slave (
        input  dataS, dataIn, inValid, outReady,
        output inReady, dataOut, outValid, contador, dataSInternal
    );

    // Producer / link side
    modport master (
        output dataS, dataIn, inValid, outReady,
        input  inReady, dataOut, outValid, contador, dataSInternal
    );
endinterface

`default_nettype wire

// File: rtl/to8bit_ser.sv
// ============================================================================
//  Module      : to8bit_ser
//  Description : Splits an 8/16/32-bit word into bytes, one per accepted cycle.
//                Define TO8BIT_LSB_FIRST_EN to send least significant byte first.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module to8bit_ser #(
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     enb,
    to8bit_ser_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  dsi_q, dsi_d;

    logic [1:0]  w_ds_norm;
    logic [1:0]  w_last_idx;
    logic        w_last;
    logic        w_in_ready;
    logic        w_load;
    logic        w_accept;
    logic [31:0] w_load_word;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;

    assign w_ds_norm = (bus.dataS == 2'b11) ? 2'b00 : bus.dataS;

    always_comb begin
        w_last_idx = 2'd0;
        case (dsi_q)
            2'b01:   w_last_idx = 2'd1;
            2'b10:   w_last_idx = 2'd3;
            default: w_last_idx = 2'd0;
        endcase
    end

    assign w_last     = (cnt_q == w_last_idx);
    assign w_in_ready = enb & ((state_q == ST_IDLE) | (bus.outReady & w_last));
    assign w_load     = enb & bus.inValid & w_in_ready;
    assign w_accept   = enb & (state_q == ST_SEND) & bus.outReady;

`ifdef TO8BIT_LSB_FIRST_EN
    always_comb begin
        w_load_word = bus.dataIn;
        case (w_ds_norm)
            2'b00:   w_load_word = {24'h0, bus.dataIn[7:0]};
            2'b01:   w_load_word = {16'h0, bus.dataIn[15:0]};
            default: w_load_word = bus.dataIn;
        endcase
    end
    assign w_shifted = {8'h00, shift_q[31:8]};
    assign w_byte    = shift_q[7:0];
`else
    // Left-align so the first byte to go out always sits in [31:24]
    always_comb begin
        w_load_word = bus.dataIn;
        case (w_ds_norm)
            2'b00:   w_load_word = {bus.dataIn[7:0], 24'h0};
            2'b01:   w_load_word = {bus.dataIn[15:0], 16'h0};
            default: w_load_word = bus.dataIn;
        endcase
    end
    assign w_shifted = {shift_q[23:0], 8'h00};
    assign w_byte    = shift_q[31:24];
`endif

    // A load on the last byte takes precedence so words stream without a bubble
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        dsi_d   = dsi_q;
        if (w_load) begin
            state_d = ST_SEND;
            shift_d = w_load_word;
            cnt_d   = 2'd0;
            dsi_d   = w_ds_norm;
        end else if (w_accept) begin
            if (w_last) begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end else begin
                shift_d = w_shifted;
                cnt_d   = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shift_q <= 32'h0;
            cnt_q   <= 2'd0;
            dsi_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            dsi_q   <= dsi_d;
        end
    end

    assign bus.inReady       = w_in_ready;
    assign bus.outValid      = (state_q == ST_SEND);
    assign bus.dataOut       = (state_q == ST_SEND) ? w_byte : IDLE_BYTE;
    assign bus.contador      = cnt_q;
    assign bus.dataSInternal = dsi_q;

endmodule

`default_nettype wire

// File: tb/tb_to8bit_ser.sv
// ============================================================================
//  Module      : tb_to8bit_ser
//  Description : Randomized and directed self-checking bench for to8bit_ser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_to8bit_ser;

    localparam logic [7:0] C_IDLE_BYTE = 8'h00;

    logic clk;
    logic rst;
    logic enb;

    to8bit_ser_if bus ();

    to8bit_ser #(.IDLE_BYTE(C_IDLE_BYTE)) u_dut (
        .clk (clk),
        .rst (rst),
        .enb (enb),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: bytes still to be emitted for the word in flight, in send order
    logic [7:0] exp_q[$];
    int         exp_idx;
    logic [1:0] exp_dsi;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [1:0] ds, input logic [31:0] di);
        logic [1:0] nds;
        int         n;
        nds = (ds == 2'b11) ? 2'b00 : ds;
        n   = (nds == 2'b10) ? 4 : (nds == 2'b01) ? 2 : 1;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
`ifdef TO8BIT_LSB_FIRST_EN
            exp_q.push_back(di[8*i +: 8]);
`else
            exp_q.push_back(di[8*(n-1-i) +: 8]);
`endif
        end
        exp_idx = 0;
        exp_dsi = nds;
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] ds,
                        input logic [31:0] di, input logic iv, input logic orr);
        logic exp_rdy;
        rst          = r;
        enb          = e;
        bus.dataS    = ds;
        bus.dataIn   = di;
        bus.inValid  = iv;
        bus.outReady = orr;
        @(negedge clk);
        exp_rdy = e && ((exp_q.size() == 0) || (orr && exp_q.size() == 1));
        chk("outValid", 32'(bus.outValid), 32'(exp_q.size() != 0));
        chk("dataOut", 32'(bus.dataOut), 32'((exp_q.size() != 0) ? exp_q[0] : C_IDLE_BYTE));
        chk("contador", 32'(bus.contador), 32'(exp_idx));
        chk("dataSInternal", 32'(bus.dataSInternal), 32'(exp_dsi));
        chk("inReady", 32'(bus.inReady), 32'(exp_rdy));
        @(posedge clk);
        if (!r) begin
            exp_q.delete();
            exp_idx = 0;
            exp_dsi = 2'b00;
        end else if (e) begin
            if (exp_q.size() != 0 && orr) begin
                void'(exp_q.pop_front());
                exp_idx = (exp_q.size() == 0) ? 0 : exp_idx + 1;
            end
            if (iv && exp_rdy) push_word(ds, di);
        end
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        enb          = 1'b1;
        bus.dataS    = 2'b00;
        bus.dataIn   = 32'h0;
        bus.inValid  = 1'b0;
        bus.outReady = 1'b0;
        exp_idx      = 0;
        exp_dsi      = 2'b00;
        @(posedge clk);
        #1;

        // Reset held with a pending word
        step(1'b0, 1'b1, 2'b10, 32'hA1B2C3D4, 1'b1, 1'b1);
        step(1'b0, 1'b1, 2'b10, 32'hA1B2C3D4, 1'b1, 1'b1);

        // 32-bit word
        step(1'b1, 1'b1, 2'b10, 32'hA1B2C3D4, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'b10, 32'h0, 1'b0, 1'b1);

        // 16-bit back-to-back
        step(1'b1, 1'b1, 2'b01, 32'h0000_1234, 1'b1, 1'b1);
        step(1'b1, 1'b1, 2'b01, 32'h0000_5678, 1'b1, 1'b1);
        step(1'b1, 1'b1, 2'b01, 32'h0000_5678, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b01, 32'h0, 1'b0, 1'b1);

        // 8-bit with junk upper bits, streaming
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b11, 32'hFFFF_FF5A, 1'b1, 1'b1);
        step(1'b1, 1'b1, 2'b11, 32'h0, 1'b0, 1'b1);

        // Back-pressure and enable
        step(1'b1, 1'b1, 2'b10, 32'hA1B2C3D4, 1'b1, 1'b1);
        step(1'b1, 1'b1, 2'b00, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'b00, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'b01, 32'h1111_1111, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b00, 32'h0, 1'b0, 1'b1);

        // Reset mid-word
        step(1'b1, 1'b1, 2'b10, 32'hA1B2C3D4, 1'b1, 1'b1);
        step(1'b1, 1'b1, 2'b10, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 2'b10, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 2'b10, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 2'b10, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 2'b10, 32'h0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 7) != 0),
                 2'($urandom),
                 $urandom,
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
